// File: rtl/slurm16_soc_if.sv
// Board-side pin bundle of the slurm16 SoC shell: video, UART, GPIO, LEDs, I2S and SPI flash.
interface slurm16_soc_if;
  logic [3:0] gpio_out;
  logic [5:0] gpio_in;
  logic [3:0] vid_r;
  logic [3:0] vid_g;
  logic [3:0] vid_b;
  logic       vid_hsync;
  logic       vid_vsync;
  logic       uart_tx;
  logic       led_r;
  logic       led_g;
  logic       led_b;
  logic       i2s_sclk;
  logic       i2s_lrclk;
  logic       i2s_data;
  logic       i2s_mclk;
  logic       flash_mosi;
  logic       flash_miso;
  logic       flash_sclk;
  logic       flash_csb;

  modport soc (
    output gpio_out, vid_r, vid_g, vid_b, vid_hsync, vid_vsync, uart_tx,
           led_r, led_g, led_b, i2s_sclk, i2s_lrclk, i2s_data, i2s_mclk,
           flash_mosi, flash_sclk, flash_csb,
    input  gpio_in, flash_miso
  );

  modport board (
    input  gpio_out, vid_r, vid_g, vid_b, vid_hsync, vid_vsync, uart_tx,
           led_r, led_g, led_b, i2s_sclk, i2s_lrclk, i2s_data, i2s_mclk,
           flash_mosi, flash_sclk, flash_csb,
    output gpio_in, flash_miso
  );
endinterface

// File: rtl/slurm16_soc.sv
// Self-running slurm16 peripheral shell: UART boot banner, solid-colour video timing,
// heartbeat GPIO/LEDs, free-running I2S clocks and an idle SPI flash port.
module slurm16_soc #(
  parameter int unsigned CLOCK_FREQ = 25000000,
  parameter int unsigned BAUD       = 115200,
  parameter logic [11:0] BG_COLOR   = 12'h00F,
  parameter int unsigned H_VIS      = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VIS      = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33
) (
  input  logic          CLK,
  input  logic          RSTb,
  slurm16_soc_if.soc    io
);

  localparam int unsigned DIV     = CLOCK_FREQ / BAUD;
  localparam int unsigned BAUD_W  = $clog2(DIV);
  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [1:0] ST_IDLE_WAIT = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_SEND      = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  localparam logic [3:0] LAST_IDX = 4'd11;

  logic [1:0]        state_q, state_d;
  logic [4:0]        wait_cnt_q, wait_cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [7:0]        data_q, data_d;
  logic              tx_q, tx_d;
  logic              led_r_q, led_r_d;
  logic              led_g_q, led_g_d;
  logic              led_b_q, led_b_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [VW-1:0]     vcnt_q, vcnt_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic [23:0]       gpio_cnt_q, gpio_cnt_d;
  logic [8:0]        i2s_cnt_q, i2s_cnt_d;

  function automatic logic [7:0] banner_byte(input logic [3:0] i);
    case (i)
      4'd0:    banner_byte = 8'h53; // S
      4'd1:    banner_byte = 8'h4C; // L
      4'd2:    banner_byte = 8'h55; // U
      4'd3:    banner_byte = 8'h52; // R
      4'd4:    banner_byte = 8'h4D; // M
      4'd5:    banner_byte = 8'h31; // 1
      4'd6:    banner_byte = 8'h36; // 6
      4'd7:    banner_byte = 8'h20;
      4'd8:    banner_byte = 8'h42; // B
      4'd9:    banner_byte = 8'h47; // G
      4'd10:   banner_byte = 8'h0D;
      4'd11:   banner_byte = 8'h0A;
      default: banner_byte = 8'h00;
    endcase
  endfunction

  // Banner FSM. Entering LOAD already drives the start bit, so LOAD is the first
  // clock of each frame and consecutive frames abut with every bit exactly DIV long.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    data_d     = data_q;
    tx_d       = tx_q;

    case (state_q)
      ST_IDLE_WAIT: begin
        if (wait_cnt_q == 5'd16) begin
          state_d    = ST_LOAD;
          tx_d       = 1'b0;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 5'd1;
        end
      end
      ST_LOAD: begin
        data_d     = banner_byte(idx_q);
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (baud_cnt_q == BAUD_W'(DIV - 1)) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 4'd9) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
              tx_d    = 1'b1;
            end else begin
              idx_d     = idx_q + 4'd1;
              state_d   = ST_LOAD;
              tx_d      = 1'b0;
              bit_cnt_d = '0;
            end
          end else begin
            // bit_cnt 0 is the start bit, 1..8 carry data[bit_cnt-1], 9 is the stop bit
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = (bit_cnt_q == 4'd8) ? 1'b1 : data_q[bit_cnt_q[2:0]];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      ST_DONE: begin
        tx_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE_WAIT;
      end
    endcase

    led_r_d = (state_d != ST_DONE);
    led_g_d = (state_d == ST_DONE);
  end

  // Video timing, colour and frame-start LED; outputs lag the counters by one clock.
  always_comb begin
    logic h_last;
    logic v_last;
    logic active;
    h_last  = (hcnt_q == HW'(H_TOTAL - 1));
    v_last  = (vcnt_q == VW'(V_TOTAL - 1));
    hcnt_d  = h_last ? '0 : hcnt_q + HW'(1);
    vcnt_d  = vcnt_q;
    if (h_last) begin
      vcnt_d = v_last ? '0 : vcnt_q + VW'(1);
    end
    active  = (hcnt_q < HW'(H_VIS)) && (vcnt_q < VW'(V_VIS));
    rgb_d   = '0;
    if (active) begin
      rgb_d = io.gpio_in[0] ? ~BG_COLOR : BG_COLOR;
    end
    hsync_d = !((hcnt_q >= HW'(H_VIS + H_FP)) && (hcnt_q < HW'(H_VIS + H_FP + H_SYNC)));
    vsync_d = !((vcnt_q >= VW'(V_VIS + V_FP)) && (vcnt_q < VW'(V_VIS + V_FP + V_SYNC)));
    led_b_d = ((hcnt_q == '0) && (vcnt_q == '0)) ? ~led_b_q : led_b_q;

    gpio_cnt_d = gpio_cnt_q + 24'd1;
    i2s_cnt_d  = i2s_cnt_q + 9'd1;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q    <= ST_IDLE_WAIT;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      led_r_q    <= 1'b1;
      led_g_q    <= 1'b0;
      led_b_q    <= 1'b0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      rgb_q      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      gpio_cnt_q <= '0;
      i2s_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      led_r_q    <= led_r_d;
      led_g_q    <= led_g_d;
      led_b_q    <= led_b_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      rgb_q      <= rgb_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      gpio_cnt_q <= gpio_cnt_d;
      i2s_cnt_q  <= i2s_cnt_d;
    end
  end

  assign io.uart_tx    = tx_q;
  assign io.led_r      = led_r_q;
  assign io.led_g      = led_g_q;
  assign io.led_b      = led_b_q;
  assign io.vid_r      = rgb_q[11:8];
  assign io.vid_g      = rgb_q[7:4];
  assign io.vid_b      = rgb_q[3:0];
  assign io.vid_hsync  = hsync_q;
  assign io.vid_vsync  = vsync_q;
  assign io.gpio_out   = gpio_cnt_q[23:20];
  assign io.i2s_mclk   = i2s_cnt_q[0];
  assign io.i2s_sclk   = i2s_cnt_q[2];
  assign io.i2s_lrclk  = i2s_cnt_q[8];
  assign io.i2s_data   = 1'b0;
  assign io.flash_csb  = 1'b1;
  assign io.flash_sclk = 1'b0;
  assign io.flash_mosi = 1'b0;

  // Upper GPIO inputs and the flash data line have no consumer in this shell.
  logic unused_inputs;
  assign unused_inputs = ^{io.gpio_in[5:1], io.flash_miso};

endmodule

// File: tb/tb_slurm16_soc.sv
// Bench for slurm16_soc: banner scoreboard with a UART decoder, plus a per-cycle
// reference model of video timing, heartbeat, I2S clocks and flash idle levels.
`timescale 1ns/1ps
module tb_slurm16_soc;
  localparam int unsigned CLK_HZ = 10000000;
  localparam int unsigned BAUD   = 115200;
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam logic [11:0] BG     = 12'h00F;
  localparam int unsigned HV = 40, HF = 4, HS = 8, HB = 6;
  localparam int unsigned VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam int unsigned FRAME_BITS = 10 * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  slurm16_soc_if bus();

  slurm16_soc #(
    .CLOCK_FREQ(CLK_HZ), .BAUD(BAUD), .BG_COLOR(BG),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .CLK (clk),
    .RSTb(rst_n),
    .io  (bus)
  );

  always #50 clk = ~clk;

  // Rising edges seen since the last reset release.
  int unsigned ncyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  banner [0:11] = '{8'h53, 8'h4C, 8'h55, 8'h52, 8'h4D, 8'h31,
                                 8'h36, 8'h20, 8'h42, 8'h47, 8'h0D, 8'h0A};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rgb"},   {bus.vid_r, bus.vid_g, bus.vid_b}, 32'h0);
    chk({tag, "_sync"},  {bus.vid_hsync, bus.vid_vsync}, 32'h3);
    chk({tag, "_uart"},  bus.uart_tx, 32'h1);
    chk({tag, "_gpio"},  bus.gpio_out, 32'h0);
    chk({tag, "_leds"},  {bus.led_r, bus.led_g, bus.led_b}, 32'h4);
    chk({tag, "_i2s"},   {bus.i2s_mclk, bus.i2s_sclk, bus.i2s_lrclk, bus.i2s_data}, 32'h0);
    chk({tag, "_flash"}, {bus.flash_csb, bus.flash_sclk, bus.flash_mosi}, 32'h4);
  endtask

  task automatic push_banner();
    for (int i = 0; i < 12; i++) exp_q.push_back(banner[i]);
  endtask

  // Reference model of video/heartbeat/I2S, checked every clock after reset release.
  initial begin : vid_mon
    logic        g;
    int unsigned pos, h, v, frames;
    logic [11:0] col;
    forever begin
      @(posedge clk);
      g = bus.gpio_in[0];
      #1;
      if (rst_n && ncyc != 0) begin
        pos    = (ncyc - 1) % FRAME;
        h      = pos % HT;
        v      = pos / HT;
        frames = (ncyc - 1) / FRAME + 1;
        col    = (h < HV && v < VV) ? (g ? (BG ^ 12'hFFF) : BG) : 12'h000;
        chk("rgb", {bus.vid_r, bus.vid_g, bus.vid_b}, 32'(col));
        chk("sync", {bus.vid_hsync, bus.vid_vsync},
            {30'd0, !(h >= HV + HF && h < HV + HF + HS), !(v >= VV + VF && v < VV + VF + VS)});
        chk("led_b", bus.led_b, frames % 2);
        chk("i2s", {bus.i2s_mclk, bus.i2s_sclk, bus.i2s_lrclk, bus.i2s_data},
            {28'd0, 1'((ncyc / 1) % 2), 1'((ncyc / 4) % 2), 1'((ncyc / 256) % 2), 1'b0});
        chk("gpio_out", bus.gpio_out, (ncyc / 1048576) % 16);
        chk("flash_idle", {bus.flash_csb, bus.flash_sclk, bus.flash_mosi}, 32'h4);
      end
    end
  end

  // UART decoder: samples each bit mid-period and pops the expected byte.
  initial begin : uart_mon
    bit          busy = 0;
    bit          low_run = 0;
    int unsigned k = 0, run = 0, byte_idx = 0;
    logic [9:0]  bits;
    logic [7:0]  got;
    logic [7:0]  e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy = 0;
        byte_idx = 0;
      end else if (!busy) begin
        if (bus.uart_tx == 1'b0) begin
          busy = 1; k = 0; run = 1; low_run = 1;
          if (byte_idx == 0) chk("first_start_cycle", ncyc, 17);
        end
      end else begin
        k++;
        if (low_run) begin
          if (bus.uart_tx == 1'b0) run++;
          else begin
            low_run = 0;
            if (byte_idx == 0) chk("start_width", run, DIV);
          end
        end
        if (k % DIV == DIV / 2) begin
          bits[k / DIV] = bus.uart_tx;
          if (k / DIV == 9) begin
            busy = 0;
            chk("start_bit", bits[0], 0);
            chk("stop_bit", bits[9], 1);
            got = bits[8:1];
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_byte: got 0x%0h expected none", got);
            end else begin
              e = exp_q.pop_front();
              chk("banner_byte", got, e);
            end
            byte_idx++;
          end
        end
      end
    end
  end

  // Random gpio_in / flash_miso activity, changed only on falling edges.
  initial begin : gpio_stim
    forever begin
      repeat ($urandom_range(30, 300)) @(negedge clk);
      bus.gpio_in    = 6'($urandom);
      bus.flash_miso = 1'($urandom);
    end
  end

  initial begin : stim
    bus.gpio_in    = 6'd0;
    bus.flash_miso = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset("reset");

    @(negedge clk);
    push_banner();
    rst_n = 1'b1;

    repeat (1000) @(negedge clk);
    chk("leds_busy", {bus.led_r, bus.led_g}, 32'h2);

    // Abort in the middle of the fifth byte.
    while (ncyc < 17 + 4 * FRAME_BITS + 300) @(negedge clk);
    chk("bytes_before_abort", exp_q.size(), 8);
    rst_n = 1'b0;
    #1 check_reset("abort");
    repeat (3) @(negedge clk);
    check_reset("abort_hold");
    exp_q.delete();
    push_banner();
    rst_n = 1'b1;

    repeat (17 + 12 * FRAME_BITS + 50) @(negedge clk);
    chk("banner_complete", exp_q.size(), 0);
    chk("leds_done", {bus.led_r, bus.led_g}, 32'h1);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (i % 100 == 0) chk("uart_idle", bus.uart_tx, 1);
    end
    chk("leds_still_done", {bus.led_r, bus.led_g}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
